fd_pipe_reg: RTL and testbench



---
 rtl/y86_pkg.sv | 49 ++++
 rtl/fd_pipe_reg_stall_wdog.sv | 50 +++++
 rtl/fd_pipe_reg.sv | 145 ++++++++++++++
 tb/tb_fd_pipe_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 constants and the fetch/decode field bundle used by
// the pipeline register bank.
package y86_pkg;

  localparam int WORD_W = 64;

  // Instruction status codes carried alongside every instruction.
  typedef enum logic [1:0] {
    ST_HLT = 2'b00,
    ST_ADR = 2'b01,
    ST_INS = 2'b10,
    ST_AOK = 2'b11
  } stat_e;

  localparam logic [1:0] STAT_AOK = 2'b11;
  localparam logic [1:0] STAT_HLT = 2'b00;
  localparam logic [1:0] STAT_ADR = 2'b01;
  localparam logic [1:0] STAT_INS = 2'b10;

  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] REG_NONE  = 4'hF;

  // Everything the D register carries from fetch into decode.
  typedef struct packed {
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [WORD_W-1:0] valc;
    logic [WORD_W-1:0] valp;
    stat_e             status;
    logic              valid;
  } d_fields_t;

  // A bubble is a nop that decode must not treat as a real instruction.
  function automatic d_fields_t bubble_fields();
    d_fields_t b;
    b.icode  = ICODE_NOP;
    b.ifun   = 4'h0;
    b.ra     = REG_NONE;
    b.rb     = REG_NONE;
    b.valc   = '0;
    b.valp   = '0;
    b.status = ST_AOK;
    b.valid  = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fd_pipe_reg_stall_wdog.sv
// stall_wdog: counts consecutive stalled cycles and raises a sticky fault
// once the stall has lasted WDOG_LIMIT cycles. WDOG_LIMIT must be 2..255.
module stall_wdog #(
  parameter int WDOG_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  output logic stall_err
);

  localparam logic [7:0] LIMIT    = 8'(WDOG_LIMIT);
  localparam logic [7:0] LIMIT_M1 = 8'(WDOG_LIMIT - 1);

  logic [7:0] wd_cnt_reg;
  logic [7:0] wd_cnt_next;
  logic       stall_err_reg;
  logic       stall_err_next;

  // Next-state: count while stalled (saturating), clear on any free cycle;
  // the fault latches on the edge that completes the WDOG_LIMIT-th stall.
  always_comb begin
    wd_cnt_next    = wd_cnt_reg;
    stall_err_next = stall_err_reg;
    if (!stall) begin
      wd_cnt_next = 8'd0;
    end else begin
      if (wd_cnt_reg < LIMIT) begin
        wd_cnt_next = wd_cnt_reg + 8'd1;
      end
      if (wd_cnt_reg >= LIMIT_M1) begin
        stall_err_next = 1'b1;
      end
    end
  end

  // State register for the counter and the sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_reg    <= 8'd0;
      stall_err_reg <= 1'b0;
    end else begin
      wd_cnt_reg    <= wd_cnt_next;
      stall_err_reg <= stall_err_next;
    end
  end

  assign stall_err = stall_err_reg;

endmodule

// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg: Y86 F (predicted PC) and D (fetch->decode) pipeline registers
// with stall/bubble control, stall watchdog and stall/bubble conflict flag.
// Optional build macro FD_PERF_CNT_EN adds saturating stall_cnt/bubble_cnt.
module fd_pipe_reg
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          WDOG_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [63:0] f_predPC,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [1:0]  f_status,
  output logic [63:0] F_predPC,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [1:0]  D_status,
`ifdef FD_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt,
`endif
  output logic        D_valid,
  output logic        stall_err,
  output logic        ctl_err
);

  logic [63:0] f_pred_reg;
  d_fields_t   d_reg;
  d_fields_t   d_next;
  logic        ctl_err_reg;
  logic        d_frozen;
  logic        d_hold;
  logic        bubble_load;

  // A real instruction with a non-AOK status parks decode until reset.
  assign d_frozen    = d_reg.valid && (d_reg.status != ST_AOK);
  assign d_hold      = D_stall || d_frozen;
  assign bubble_load = !d_hold && D_bubble;

  // F register: hold on F_stall, otherwise take the next predicted PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pred_reg <= RESET_PC;
    end else if (!F_stall) begin
      f_pred_reg <= f_predPC;
    end
  end

  // D next-state: hold beats bubble, bubble beats a normal load.
  always_comb begin
    d_next = d_reg;
    if (d_hold) begin
      d_next = d_reg;
    end else if (D_bubble) begin
      d_next = bubble_fields();
    end else begin
      d_next.icode  = f_icode;
      d_next.ifun   = f_ifun;
      d_next.ra     = f_rA;
      d_next.rb     = f_rB;
      d_next.valc   = f_valC;
      d_next.valp   = f_valP;
      d_next.status = stat_e'(f_status);
      d_next.valid  = 1'b1;
    end
  end

  // D register; reset leaves a bubble in decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg <= bubble_fields();
    end else begin
      d_reg <= d_next;
    end
  end

  // Sticky flag for the control logic asking to stall and bubble at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_err_reg <= 1'b0;
    end else if (D_stall && D_bubble) begin
      ctl_err_reg <= 1'b1;
    end
  end

  stall_wdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_stall_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (F_stall),
    .stall_err(stall_err)
  );

`ifdef FD_PERF_CNT_EN
  // Index 0 counts D_stall cycles, index 1 counts bubbles actually loaded.
  logic [1:0]       perf_inc;
  logic [1:0][31:0] perf_cnt;

  assign perf_inc = {bubble_load, D_stall};

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    logic [31:0] cnt_reg;

    // Saturating event counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= 32'd0;
      end else if (perf_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end

    assign perf_cnt[gi] = cnt_reg;
  end

  assign stall_cnt  = perf_cnt[0];
  assign bubble_cnt = perf_cnt[1];
`endif

  assign F_predPC = f_pred_reg;
  assign D_icode  = d_reg.icode;
  assign D_ifun   = d_reg.ifun;
  assign D_rA     = d_reg.ra;
  assign D_rB     = d_reg.rb;
  assign D_valC   = d_reg.valc;
  assign D_valP   = d_reg.valp;
  assign D_status = d_reg.status;
  assign D_valid  = d_reg.valid;
  assign ctl_err  = ctl_err_reg;

endmodule

// File: tb/tb_fd_pipe_reg.sv
// tb_fd_pipe_reg: directed checks of the F/D pipeline register bank.
module tb_fd_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        F_stall, D_stall, D_bubble;
  logic [63:0] f_predPC, f_valC, f_valP;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [1:0]  f_status;
  logic [63:0] F_predPC, D_valC, D_valP;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [1:0]  D_status;
  logic        D_valid, stall_err, ctl_err;
`ifdef FD_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fd_pipe_reg #(
    .RESET_PC  (64'h0),
    .WDOG_LIMIT(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .F_stall   (F_stall),
    .D_stall   (D_stall),
    .D_bubble  (D_bubble),
    .f_predPC  (f_predPC),
    .f_icode   (f_icode),
    .f_ifun    (f_ifun),
    .f_rA      (f_rA),
    .f_rB      (f_rB),
    .f_valC    (f_valC),
    .f_valP    (f_valP),
    .f_status  (f_status),
    .F_predPC  (F_predPC),
    .D_icode   (D_icode),
    .D_ifun    (D_ifun),
    .D_rA      (D_rA),
    .D_rB      (D_rB),
    .D_valC    (D_valC),
    .D_valP    (D_valP),
    .D_status  (D_status),
`ifdef FD_PERF_CNT_EN
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
`endif
    .D_valid   (D_valid),
    .stall_err (stall_err),
    .ctl_err   (ctl_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1ns so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp,
                         input logic [1:0] st, input logic [63:0] pc);
    f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb;
    f_valC = vc; f_valP = vp; f_status = st; f_predPC = pc;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".icode"}, 64'(D_icode), 64'h1);
    chk({tag, ".rA"}, 64'(D_rA), 64'hF);
    chk({tag, ".rB"}, 64'(D_rB), 64'hF);
    chk({tag, ".valid"}, 64'(D_valid), 64'h0);
    chk({tag, ".status"}, 64'(D_status), 64'h3);
  endtask

  initial begin
    rst_n = 1'b0;
    F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    drive_f(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 2'b11, 64'h0);
    step();
    step();

    // Reset state
    chk("rst.predPC", F_predPC, 64'h0);
    chk_bubble("rst");
    chk("rst.valC", D_valC, 64'h0);
    chk("rst.stall_err", 64'(stall_err), 64'h0);
    chk("rst.ctl_err", 64'(ctl_err), 64'h0);
`ifdef FD_PERF_CNT_EN
    chk("rst.stall_cnt", 64'(stall_cnt), 64'h0);
    chk("rst.bubble_cnt", 64'(bubble_cnt), 64'h0);
`endif
    $display("vec reset: F_predPC=%h D_icode=%h D_valid=%b", F_predPC, D_icode, D_valid);

    // Plain load: one cycle latency
    drive_f(4'h3, 4'h0, 4'hF, 4'h2, 64'h10, 64'h0A, 2'b11, 64'h0A);
    rst_n = 1'b1;
    step();
    chk("load.icode", 64'(D_icode), 64'h3);
    chk("load.rB", 64'(D_rB), 64'h2);
    chk("load.valC", D_valC, 64'h10);
    chk("load.valP", D_valP, 64'h0A);
    chk("load.valid", 64'(D_valid), 64'h1);
    chk("load.predPC", F_predPC, 64'h0A);
    $display("vec load: D_icode=%h D_valC=%h D_valid=%b", D_icode, D_valC, D_valid);

    // Bubble
    D_bubble = 1'b1;
    step();
    D_bubble = 1'b0;
    chk_bubble("bub");
    chk("bub.valC", D_valC, 64'h0);
    $display("vec bubble: D_icode=%h D_valid=%b", D_icode, D_valid);

    // Load, then stall F and D for three cycles while inputs change
    drive_f(4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h0C, 2'b11, 64'h0C);
    step();
    chk("pre.icode", 64'(D_icode), 64'h6);
    F_stall = 1'b1; D_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_f(4'h2, 4'h0, 4'(i), 4'h4, 64'(i), 64'h20, 2'b11, 64'h20 + 64'(i));
      step();
      chk("stall.icode", 64'(D_icode), 64'h6);
      chk("stall.rA", 64'(D_rA), 64'h2);
      chk("stall.predPC", F_predPC, 64'h0C);
    end
    F_stall = 1'b0; D_stall = 1'b0;
    step();
    chk("rel.icode", 64'(D_icode), 64'h2);
    chk("rel.rA", 64'(D_rA), 64'h2);
    chk("rel.predPC", F_predPC, 64'h22);
    $display("vec stall-release: D_icode=%h F_predPC=%h", D_icode, F_predPC);

    // Stall + bubble conflict: stall wins, ctl_err sticky
    drive_f(4'h5, 4'h0, 4'h1, 4'h7, 64'h8, 64'h30, 2'b11, 64'h30);
    D_stall = 1'b1; D_bubble = 1'b1;
    step();
    chk("conf.icode", 64'(D_icode), 64'h2);
    chk("conf.valid", 64'(D_valid), 64'h1);
    chk("conf.ctl_err", 64'(ctl_err), 64'h1);
    D_stall = 1'b0; D_bubble = 1'b0;
    step();
    chk("conf2.ctl_err", 64'(ctl_err), 64'h1);
    chk("conf2.icode", 64'(D_icode), 64'h5);
    $display("vec conflict: ctl_err=%b D_icode=%h", ctl_err, D_icode);

    // Watchdog: 15 stalled cycles is fine
    F_stall = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("wd15.stall_err", 64'(stall_err), 64'h0);
    F_stall = 1'b0;
    step();
    chk("wd15rel.stall_err", 64'(stall_err), 64'h0);
    $display("vec wdog15: stall_err=%b", stall_err);

    // Watchdog: 16th consecutive stalled edge raises the fault
    F_stall = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("wd16pre.stall_err", 64'(stall_err), 64'h0);
    step();
    chk("wd16.stall_err", 64'(stall_err), 64'h1);
    F_stall = 1'b0;
    step();
    chk("wd16rel.stall_err", 64'(stall_err), 64'h1);
    $display("vec wdog16: stall_err=%b", stall_err);

    // HLT captured freezes D; F still advances
    drive_f(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h40, 2'b00, 64'h40);
    step();
    chk("hlt.status", 64'(D_status), 64'h0);
    chk("hlt.valid", 64'(D_valid), 64'h1);
    drive_f(4'h3, 4'h0, 4'hF, 4'h1, 64'h99, 64'h50, 2'b11, 64'h50);
    step();
    chk("frz.icode", 64'(D_icode), 64'h0);
    chk("frz.status", 64'(D_status), 64'h0);
    chk("frz.predPC", F_predPC, 64'h50);
    D_bubble = 1'b1;
    step();
    D_bubble = 1'b0;
    chk("frzbub.valid", 64'(D_valid), 64'h1);
    chk("frzbub.valP", D_valP, 64'h40);
    $display("vec halt-freeze: D_status=%b D_icode=%h", D_status, D_icode);

    // Asynchronous reset mid-cycle, also mid-stall
    F_stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_bubble("arst");
    chk("arst.predPC", F_predPC, 64'h0);
    chk("arst.stall_err", 64'(stall_err), 64'h0);
    chk("arst.ctl_err", 64'(ctl_err), 64'h0);
    step();
    F_stall = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post.icode", 64'(D_icode), 64'h3);
    chk("post.valC", D_valC, 64'h99);
    chk("post.predPC", F_predPC, 64'h50);
    $display("vec post-reset: D_icode=%h F_predPC=%h", D_icode, F_predPC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
